// File: rtl/reg8file_scan_if.sv
// reg8file_scan_if
//   Beat stream from the register-file scanner to its consumer.
//   Parameters:
//     DW - payload width (register file word width)
//     AW - register index width
//   Signals:
//     out_data  - beat payload (register contents or checksum)
//     out_idx   - register index the beat belongs to
//     out_valid - beat valid
//     out_ready - consumer accepts the beat
//     out_last  - final beat of the scan
//     out_csum  - beat carries the XOR checksum rather than register data
//   Modports:
//     master - the scanner (drives the beat, samples out_ready)
//     slave  - the consumer
interface reg8file_scan_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_idx;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          out_csum;

  modport master (
    output out_data,
    output out_idx,
    output out_valid,
    output out_last,
    output out_csum,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_idx,
    input  out_valid,
    input  out_last,
    input  out_csum,
    output out_ready
  );
endinterface

// File: rtl/reg8file_scan.sv
// reg8file_scan
//   Read-side sequencer for an 8x8 register file. A start request latches a
//   first/last index pair; the block then walks the file's read select from
//   first to last (wrapping past the top index) and emits one beat per
//   register on a valid/ready stream.
//
//   Optional feature: define REG8FILE_SCAN_CSUM_EN to append one checksum
//   beat (XOR of all data beats) after the last data beat. Without it the
//   checksum state and accumulator do not exist and out_csum is tied low.
//
//   Ports:
//     clk    - rising-edge clock
//     clr    - asynchronous active-low reset
//     start  - scan request, sampled only while idle
//     first  - first index of the scan, latched with start
//     last   - last index of the scan, latched with start
//     busy   - scan in progress
//     rsel   - registered read select to the register file
//     rdata  - combinational read data from the register file
//     done   - one-cycle pulse in the first idle cycle after the scan
//     stream - beat output (master side of reg8file_scan_if)
module reg8file_scan #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic [AW-1:0] first,
  input  logic [AW-1:0] last,
  output logic          busy,
  output logic [AW-1:0] rsel,
  input  logic [DW-1:0] rdata,
  output logic          done,
  reg8file_scan_if.master stream
);

`ifdef REG8FILE_SCAN_CSUM_EN
  typedef enum logic [1:0] {IDLE, READ, OUT, CSUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, READ, OUT} state_t;
`endif

  state_t        state;
  logic [AW-1:0] last_idx;

`ifdef REG8FILE_SCAN_CSUM_EN
  logic [DW-1:0] acc;
`else
  assign stream.out_csum = 1'b0;
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state            <= IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      rsel             <= '0;
      last_idx         <= '0;
      stream.out_data  <= '0;
      stream.out_idx   <= '0;
      stream.out_valid <= 1'b0;
      stream.out_last  <= 1'b0;
`ifdef REG8FILE_SCAN_CSUM_EN
      stream.out_csum  <= 1'b0;
      acc              <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // rsel is only touched when a scan is accepted, so it keeps
          // pointing at the last register read while idle.
          if (start) begin
            last_idx <= last;
            rsel     <= first;
            busy     <= 1'b1;
`ifdef REG8FILE_SCAN_CSUM_EN
            acc      <= '0;
`endif
            state    <= READ;
          end
        end

        READ: begin
          // rsel was registered last cycle, so rdata is settled here.
          stream.out_data  <= rdata;
          stream.out_idx   <= rsel;
          stream.out_valid <= 1'b1;
`ifdef REG8FILE_SCAN_CSUM_EN
          stream.out_last  <= 1'b0;
          stream.out_csum  <= 1'b0;
`else
          stream.out_last  <= (rsel == last_idx);
`endif
          state <= OUT;
        end

        OUT: begin
          if (stream.out_valid && stream.out_ready) begin
            stream.out_valid <= 1'b0;
`ifdef REG8FILE_SCAN_CSUM_EN
            acc <= acc ^ stream.out_data;
`endif
            if (rsel == last_idx) begin
`ifdef REG8FILE_SCAN_CSUM_EN
              state <= CSUM;
`else
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
`endif
            end else begin
              // Natural overflow of the AW-bit select gives the 7 -> 0 wrap.
              rsel  <= rsel + 1'b1;
              state <= READ;
            end
          end
        end

`ifdef REG8FILE_SCAN_CSUM_EN
        CSUM: begin
          // First cycle loads the checksum beat (acc already holds the last
          // data beat), then it waits for its handshake like any data beat.
          if (!stream.out_valid) begin
            stream.out_data  <= acc;
            stream.out_idx   <= last_idx;
            stream.out_csum  <= 1'b1;
            stream.out_last  <= 1'b1;
            stream.out_valid <= 1'b1;
          end else if (stream.out_ready) begin
            stream.out_valid <= 1'b0;
            state            <= IDLE;
            busy             <= 1'b0;
            done             <= 1'b1;
          end
        end
`endif

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg8file_scan.sv
// tb_reg8file_scan
//   Bench for reg8file_scan. A behavioural register file feeds rdata; a
//   queue model lists the beats a scan must produce, and a monitor process
//   compares every accepted beat and every stalled cycle against it.
module tb_reg8file_scan;
  localparam int DW = 8;
  localparam int AW = 3;

`ifdef REG8FILE_SCAN_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic          clk;
  logic          clr;
  logic          start;
  logic [AW-1:0] first;
  logic [AW-1:0] last;
  logic          busy;
  logic [AW-1:0] rsel;
  logic [DW-1:0] rdata;
  logic          done;
  logic [DW-1:0] regs [8];

  reg8file_scan_if #(.DW(DW), .AW(AW)) sif ();

  reg8file_scan #(.DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .first (first),
    .last  (last),
    .busy  (busy),
    .rsel  (rsel),
    .rdata (rdata),
    .done  (done),
    .stream(sif.master)
  );

  assign rdata = regs[rsel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [2:0] idx;
    logic       lst;
    logic       cs;
  } beat_t;

  beat_t      exp_q [$];
  beat_t      e;
  int         checks = 0;
  int         errors = 0;
  int         rcv_cnt = 0;
  logic [2:0] rcv_idx [$];
  logic [7:0] rcv_data [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected beat list for a scan, straight from the range rule.
  function automatic int build_model(input int f, input int l);
    int n;
    logic [7:0] x;
    beat_t b;
    n = (((l - f) % 8) + 8) % 8 + 1;
    x = 8'h00;
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      b.idx  = 3'((f + k) % 8);
      b.data = regs[b.idx];
      b.lst  = (k == n - 1) && !CSUM_EN;
      b.cs   = 1'b0;
      x      = x ^ b.data;
      exp_q.push_back(b);
    end
    if (CSUM_EN) begin
      b.data = x;
      b.idx  = 3'(l);
      b.lst  = 1'b1;
      b.cs   = 1'b1;
      exp_q.push_back(b);
    end
    return n;
  endfunction

  // Monitor: checks every accepted beat against the model and holds
  // payload/rsel steady across stalls.
  logic       pstall = 1'b0;
  logic [7:0] pdata;
  logic [2:0] pidx;
  logic [2:0] prsel;
  always @(negedge clk) begin
    #1;
    if (clr !== 1'b1) begin
      pstall = 1'b0;
    end else begin
      if (pstall) begin
        chk("stall_valid", 32'(sif.out_valid), 32'd1);
        chk("stall_data", 32'(sif.out_data), 32'(pdata));
        chk("stall_idx", 32'(sif.out_idx), 32'(pidx));
        chk("stall_rsel", 32'(rsel), 32'(prsel));
      end
      if (done) chk("done_busy_low", 32'(busy), 32'd0);
      if (sif.out_valid && sif.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got idx %0d data %0h expected no beat", sif.out_idx, sif.out_data);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 32'(sif.out_data), 32'(e.data));
          chk("beat_idx", 32'(sif.out_idx), 32'(e.idx));
          chk("beat_last", 32'(sif.out_last), 32'(e.lst));
          chk("beat_csum", 32'(sif.out_csum), 32'(e.cs));
        end
        rcv_cnt++;
        rcv_idx.push_back(sif.out_idx);
        rcv_data.push_back(sif.out_data);
      end
      pstall = sif.out_valid && !sif.out_ready;
      pdata  = sif.out_data;
      pidx   = sif.out_idx;
      prsel  = rsel;
    end
  end

  // Runs one scan. done_at = edge (counted from the start edge as 0) at
  // which done is first sampled high.
  task automatic run_scan(input int f, input int l, input int stall_beat,
                          input int mid_start, output int done_at);
    int  hs;
    int  stall_left;
    bit  stalled;
    bit  got;
    void'(build_model(f, l));
    rcv_cnt = 0;
    rcv_idx.delete();
    rcv_data.delete();
    hs = 0;
    stall_left = 0;
    stalled = 1'b0;
    got = 1'b0;
    done_at = -1;
    @(negedge clk);
    start = 1'b1;
    first = 3'(f);
    last  = 3'(l);
    sif.out_ready = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 0) begin
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("rsel_first", 32'(rsel), 32'(f));
      end
      if (k == 1) chk("valid_after_edge1", 32'(sif.out_valid), 32'd1);
      if (k == mid_start) begin
        start = 1'b1;
        first = 3'd4;
        last  = 3'd4;
      end
      if (done) begin
        got = 1'b1;
        done_at = k + 1;
      end
      if (!stalled && stall_beat >= 0 && hs == stall_beat && sif.out_valid) begin
        stall_left = 5;
        stalled = 1'b1;
      end
      sif.out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      if (sif.out_ready && sif.out_valid) hs++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL scan_timeout: got no done expected done within 400 cycles");
    end
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    @(negedge clk);
    chk("no_second_scan", 32'(busy), 32'd0);
    chk("rsel_hold", 32'(rsel), 32'(l));
    chk("beats_left", 32'(exp_q.size()), 32'd0);
  endtask

  // Starts a 0..7 scan and pulls clr low while beat 3 is on the bus.
  task automatic abort_scan();
    int  hs;
    bit  hit;
    void'(build_model(0, 7));
    hs = 0;
    hit = 1'b0;
    @(negedge clk);
    start = 1'b1;
    first = 3'd0;
    last  = 3'd7;
    sif.out_ready = 1'b1;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (hs == 3 && sif.out_valid) begin
        hit = 1'b1;
        clr = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(sif.out_valid), 32'd0);
        chk("abort_last", 32'(sif.out_last), 32'd0);
        chk("abort_csum", 32'(sif.out_csum), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_rsel", 32'(rsel), 32'd0);
        chk("abort_idx", 32'(sif.out_idx), 32'd0);
        chk("abort_data", 32'(sif.out_data), 32'd0);
        exp_q.delete();
      end else if (sif.out_valid) begin
        hs++;
      end
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL abort_timeout: got no beat 3 expected beat 3 within 100 cycles");
    end
    repeat (2) @(negedge clk);
    clr = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_idle", 32'(busy), 32'd0);
    end
  endtask

  int d;
  int n;

  initial begin
    start = 1'b0;
    first = 3'd0;
    last  = 3'd0;
    sif.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) regs[i] = 8'(8'h10 + i);
    clr = 1'b1;
    #3 clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(sif.out_valid), 32'd0);
    chk("rst_last", 32'(sif.out_last), 32'd0);
    chk("rst_csum", 32'(sif.out_csum), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rsel", 32'(rsel), 32'd0);
    chk("rst_idx", 32'(sif.out_idx), 32'd0);
    chk("rst_data", 32'(sif.out_data), 32'd0);
    clr = 1'b1;

    // Pin the model with hand-worked values.
    n = build_model(0, 7);
    chk("model_full_cnt", 32'(n), 32'd8);
    chk("model_full_first", 32'(exp_q[0].data), 32'h10);
    chk("model_full_last", 32'(exp_q[7].data), 32'h17);
    n = build_model(6, 1);
    chk("model_wrap_cnt", 32'(n), 32'd4);
    n = build_model(2, 1);
    chk("model_all_cnt", 32'(n), 32'd8);
    exp_q.delete();

    // Full scan with ready held high.
    run_scan(0, 7, -1, -1, d);
    $display("scan 0..7: done at edge %0d, %0d beats", d, rcv_cnt);
    chk("full_done_edge", 32'(d), CSUM_EN ? 32'd19 : 32'd17);
    chk("full_beats", 32'(rcv_cnt), CSUM_EN ? 32'd9 : 32'd8);
    chk("full_idx0", 32'(rcv_idx[0]), 32'd0);
    chk("full_data7", 32'(rcv_data[7]), 32'h17);
    if (CSUM_EN) chk("full_csum_data", 32'(rcv_data[8]), 32'h00);

    // Wrapping range.
    run_scan(6, 1, -1, -1, d);
    $display("scan 6..1: done at edge %0d, %0d beats", d, rcv_cnt);
    chk("wrap_beats", 32'(rcv_cnt), CSUM_EN ? 32'd5 : 32'd4);
    chk("wrap_idx0", 32'(rcv_idx[0]), 32'd6);
    chk("wrap_idx1", 32'(rcv_idx[1]), 32'd7);
    chk("wrap_idx2", 32'(rcv_idx[2]), 32'd0);
    chk("wrap_idx3", 32'(rcv_idx[3]), 32'd1);
    chk("wrap_done_edge", 32'(d), CSUM_EN ? 32'd11 : 32'd9);

    // Single beat.
    regs[3] = 8'hA5;
    run_scan(3, 3, -1, -1, d);
    $display("scan 3..3: done at edge %0d, %0d beats", d, rcv_cnt);
    chk("single_beats", 32'(rcv_cnt), CSUM_EN ? 32'd2 : 32'd1);
    chk("single_data", 32'(rcv_data[0]), 32'hA5);
    if (CSUM_EN) chk("single_csum_data", 32'(rcv_data[1]), 32'hA5);
    chk("single_done_edge", 32'(d), CSUM_EN ? 32'd5 : 32'd3);

    // Backpressure on beat 2 for five cycles.
    run_scan(0, 7, 2, -1, d);
    $display("scan 0..7 stalled: done at edge %0d, %0d beats", d, rcv_cnt);
    chk("stall_beats", 32'(rcv_cnt), CSUM_EN ? 32'd9 : 32'd8);
    chk("stall_done_edge", 32'(d), CSUM_EN ? 32'd24 : 32'd22);

    // Start pulse mid-scan must be ignored.
    run_scan(0, 7, -1, 5, d);
    $display("scan 0..7 with stray start: done at edge %0d, %0d beats", d, rcv_cnt);
    chk("ignore_beats", 32'(rcv_cnt), CSUM_EN ? 32'd9 : 32'd8);
    chk("ignore_done_edge", 32'(d), CSUM_EN ? 32'd19 : 32'd17);
    chk("ignore_idx3", 32'(rcv_idx[3]), 32'd3);

    // Reset during beat 3, then a clean scan.
    abort_scan();
    $display("abort during beat 3 complete");
    run_scan(2, 5, -1, -1, d);
    $display("scan 2..5 after reset: done at edge %0d, %0d beats", d, rcv_cnt);
    chk("post_rst_beats", 32'(rcv_cnt), CSUM_EN ? 32'd5 : 32'd4);
    chk("post_rst_data1", 32'(rcv_data[1]), 32'hA5);
    chk("post_rst_done_edge", 32'(d), CSUM_EN ? 32'd11 : 32'd9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg8file_scan.md
# reg8file_scan

Read-side sequencer for the 8×8 register file. On `start` it drives the file's 3-bit read select across a programmable index range. It captures each combinational read value and streams it out as one beat per register over a valid/ready handshake. It sits between a register file instance (`rsel`/`q`) and any downstream consumer such as a debug dump, serializer or bus bridge.

## Interface
- `DW`, default 8: data width; must match the register file word width.
- `AW`, default 3: index width; the file has 2^AW = 8 entries.
- `clk`  in  1: rising-edge clock.
- `clr`  in  1: asynchronous, active-low reset. Low clears all state immediately.
- `start`  in  1: request a scan. Sampled only in IDLE.
- `first`  in  AW: first index of the scan. Latched with `start`.
- `last`  in  AW: last index of the scan. Latched with `start`.
- `busy`  out  1: high from the cycle after an accepted `start` until scan completion.
- `rsel`  out  AW: read select to the register file. Registered.
- `rdata`  in  DW: register file read data (`q`). Combinational function of `rsel`.
- `out_data`  out  DW: beat payload.
- `out_idx`  out  AW: register index of the beat.
- `out_valid`  out  1: beat valid.
- `out_ready`  in  1: consumer accepts the beat.
- `out_last`  out  1: marks the final beat of the scan.
- `out_csum`  out  1: marks a checksum beat. Constant 0 when the checksum feature is compiled out.
- `done`  out  1: one-cycle pulse after the final beat is accepted.

## Operation
- FSM has four states: IDLE, READ, OUT and CSUM. CSUM exists only with the macro.
- **IDLE.** When `start` = 1:
  - latch `last`;
  - set `rsel` <= `first`;
  - clear the checksum accumulator;
  - go to READ.
- **READ** (one cycle). Capture the beat:
  - `out_data` <= `rdata`;
  - `out_idx` <= `rsel`;
  - `out_valid` <= 1;
  - `out_last` <= (`rsel` == latched last) and the checksum feature is compiled out.
  - Go to OUT.
- **OUT.** Hold all `out_*` outputs stable while `out_valid` && !`out_ready`. On handshake (`out_valid` && `out_ready`):
  - `out_valid` <= 0;
  - XOR `out_data` into the accumulator.
  - If `rsel` == latched last: go to CSUM when the macro is defined, otherwise to IDLE with `done` pulsed.
  - Otherwise: `rsel` <= `rsel` + 1, wrapping modulo 8 (7 -> 0), and go to READ.
- **Range rule.** Beat count = ((last − first) mod 8) + 1.
  - `first` == `last` produces exactly 1 beat.
  - `last` < `first` wraps through index 7 to 0.
  - `first` = `last` + 1 (mod 8) produces all 8 beats.
- **`start` while busy** is ignored. `first`/`last` changes mid-scan have no effect.
- **`rsel` in IDLE** holds its last value and is never written by this block outside a scan.
- **`done`** is high for exactly one cycle, the first IDLE cycle after completion. `busy` is 0 in that same cycle.

## Timing
- **Reset values.** `busy`, `out_valid`, `out_last`, `out_csum` and `done` = 0. `rsel`, `out_idx` and `out_data` = 0. State = IDLE.
- **Reset mid-scan.** The scan aborts immediately. No `done` is pulsed and the beat in flight is dropped.
- **Latency.**
  - `start` sampled at edge 0.
  - `busy` = 1 and `rsel` = `first` after edge 0.
  - `out_valid` = 1 after edge 1.
- **Throughput.** With `out_ready` held high, one beat every 2 cycles. An N-beat scan ends with `done` 2N+1 cycles after the `start` edge (2N+3 with checksum).
- **Handshake.** `out_valid` never drops without a handshake. Payload is unchanged while stalled. `out_ready` may toggle freely.

## Configuration
- `REG8FILE_SCAN_CSUM_EN` defined: after the last data beat is accepted, the FSM enters CSUM and emits one extra beat:
  - `out_data` = XOR of all data beats;
  - `out_idx` = latched last;
  - `out_csum` = 1;
  - `out_last` = 1.
  - `done` pulses after that beat is accepted. Data beats all carry `out_last` = 0.
- Not defined: no CSUM state and no accumulator. `out_csum` is tied to 0. `out_last` marks the final data beat.

## Test plan
- **Full scan, ready=1.** File preloaded with r[i] = 8'h10+i. `first`=0, `last`=7. Required: 8 beats with data 10..17 and idx 0..7, `out_last` on idx 7, `done` 17 cycles after `start`. With the macro: a ninth beat with data 8'h00 and `out_csum`=1.
- **Wrap range.** `first`=6, `last`=1. Required: beats with idx 6, 7, 0, 1 in that order; exactly 4 beats.
- **Single beat.** `first`=`last`=3, r3 = 8'hA5. Required: one beat with data A5, `out_last`=1. With the macro: a checksum beat with data A5.
- **Backpressure.** `out_ready` low for 5 cycles on beat 2. Required: `out_data`/`out_idx`/`out_valid` stable throughout; no beat lost or duplicated; `rsel` does not advance.
- **Ignored start.** Pulse `start` with `first`=4 mid-scan of 0..7. Required: the original scan completes unchanged; no second scan begins.
- **Reset mid-scan.** Drive `clr` low during beat 3. Required: all outputs return to their reset values asynchronously and no `done` is pulsed. A new `start` after `clr` returns high scans normally.
